vec_mag_path_acc: RTL and testbench
===================================

Name: vec_mag_path_acc

Overview:
- Downstream consumer of vec_mag_core's magnitude stream.
- Accumulates per-packet statistics over tlast-delimited packets of magnitudes: saturating sum (path length), maximum magnitude and beat count.
- Emits one result beat per input packet on an AXI-Stream master, with per-packet error flags in tuser.

Parameters:
- COORD_WIDTH, 8: coordinate width of the upstream core. Input tdata width is 4*COORD_WIDTH.
- MAG_WIDTH, 16: number of low input bits treated as the magnitude. Must be ≤ 4*COORD_WIDTH.
- SUM_WIDTH, 32: width of the packet-sum accumulator.
- CNT_WIDTH, 16: width of the beat counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tdata  in  4*COORD_WIDTH  unsigned magnitude from vec_mag_core.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of the packet.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  CNT_WIDTH+MAG_WIDTH+SUM_WIDTH  {count, max, sum}; count occupies the MSBs.
- m_axis_tuser  out  2  bit0 = sum or count saturated; bit1 = input magnitude clamped.
- m_axis_tvalid  out  1  result valid.
- m_axis_tlast  out  1  equals m_axis_tvalid (every result is a one-beat packet).
- m_axis_tready  in  1  downstream accept.

Behaviour:
- Reset: reset is aresetn, synchronous, active-low; clock is aclk. While aresetn=0, all of the following hold at the next edge:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0;
  - sum, max, count and sticky flags cleared;
  - FSM returns to IDLE.
  - Reset mid-packet discards the partial packet; no result is ever emitted for it.
- s_axis_tready = !m_axis_tvalid || m_axis_tready. This is combinational from registered state and m_axis_tready only; it is independent of s_axis_tvalid.
- Input accept occurs when s_axis_tvalid && s_axis_tready.
- Magnitude extraction:
  - mag = s_axis_tdata[MAG_WIDTH-1:0].
  - If any bit of s_axis_tdata[4*COORD_WIDTH-1:MAG_WIDTH] is set, mag is clamped to all-ones and the sticky clamp flag is set.
- Per accepted beat:
  - sum_next = sum + mag. If the result exceeds 2^SUM_WIDTH-1, it is clamped there and the sticky saturation flag is set.
  - count_next = count + 1, saturating at 2^CNT_WIDTH-1, which also sets the sticky saturation flag.
  - max_next = (mag > max) ? mag : max.
- FSM states:
  - IDLE: no beats accumulated. Accepting a beat with tlast=0 moves to ACCUM. Accepting a beat with tlast=1 emits a result and stays in IDLE.
  - ACCUM: accepting a beat with tlast=0 stays in ACCUM. Accepting a beat with tlast=1 emits a result and returns to IDLE.
- Emit:
  - On the tlast beat, the result register is loaded with the final values including that beat: {count_next, max_next, sum_next}, and tuser = the flags including that beat.
  - m_axis_tvalid=1 from the next cycle; latency is 1 cycle from tlast acceptance to tvalid.
  - Accumulators and flags reset to zero in the same edge.
- Output holding: m_axis_tdata and m_axis_tuser are held stable while m_axis_tvalid && !m_axis_tready.
- Simultaneous events:
  - An output handshake and an input accept in the same cycle are both legal.
  - If that input beat is a tlast, the new result loads in the same edge the old one drains. Back-to-back single-beat packets therefore sustain 1 result per cycle.
- Stall: while the result is pending and not accepted, input is stalled (tready=0). Accumulators hold.
- Bubbles: gaps in s_axis_tvalid have no effect on state.

Decomposition:
- Package vec_mag_pkg:
  - COORD_WIDTH default;
  - AXIS width localparam (4*COORD_WIDTH);
  - packed struct vec_mag_result_t {count, max, sum};
  - TUSER_SAT=0 and TUSER_CLAMP=1 bit indices;
  - FSM state enum {IDLE, ACCUM}.
- One natural sub-module: vec_mag_sat_add, a parameterised combinational saturating adder returning {result, overflow}. It is instantiated for both sum and count.

Test Plan:
- Packet of mags 3, 4, 5 (tlast on 5), m_tready=1 → one result one cycle after the last beat: sum=12, max=5, count=3, tuser=0, tlast=1.
- Single-beat packet mag=361 (max for 8-bit coords) → sum=361, max=361, count=1. Ten back-to-back single-beat packets → ten results on consecutive cycles.
- Packet {10, 20} then m_tready=0 for 5 cycles while packet {1, 2, 3} is offered:
  - result {2, 20, 30} is held stable and s_tready=0;
  - after release, the second result is {3, 3, 6};
  - no beats are lost or duplicated.
- Override SUM_WIDTH=10; packet {600, 600} → sum=1023, max=600, count=2, tuser[0]=1. The next packet {1} has tuser=0.
- Input tdata=0x0001_0000 single-beat → max=0xFFFF, sum=0xFFFF, tuser[1]=1.
- Two beats {50, 60} without tlast, aresetn low one cycle, then packet {7} → only result is sum=7, max=7, count=1. m_axis_tvalid stays 0 during reset.

Source files
------------

// File: rtl/vec_mag_pkg.sv
// Shared definitions for the vec_mag path accumulator.
//   - default widths of the upstream core and of the result fields
//   - packed result layout {count, max, sum}, count in the MSBs
//   - tuser bit positions for the per-packet error flags
//   - accumulator FSM state encoding
package vec_mag_pkg;

  localparam int COORD_WIDTH_DEF = 8;
  localparam int AXIS_WIDTH      = 4 * COORD_WIDTH_DEF;
  localparam int MAG_WIDTH_DEF   = 16;
  localparam int SUM_WIDTH_DEF   = 32;
  localparam int CNT_WIDTH_DEF   = 16;

  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0] count;
    logic [MAG_WIDTH_DEF-1:0] max;
    logic [SUM_WIDTH_DEF-1:0] sum;
  } vec_mag_result_t;

  localparam int TUSER_SAT   = 0;
  localparam int TUSER_CLAMP = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } vec_mag_state_e;

endpackage

// File: rtl/vec_mag_sat_add.sv
// Combinational unsigned saturating adder.
// Ports:
//   a, b      in  WIDTH  operands
//   result    out WIDTH  a + b, clamped to all-ones on carry out
//   overflow  out 1      set when the true sum did not fit in WIDTH bits
module vec_mag_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw      = {1'b0, a} + {1'b0, b};
    overflow = raw[WIDTH];
    result   = raw[WIDTH] ? '1 : raw[WIDTH-1:0];
  end

endmodule

// File: rtl/vec_mag_path_acc.sv
// Per-packet statistics over a tlast-delimited stream of magnitudes:
// saturating sum (path length), maximum magnitude and beat count. One
// result beat is produced per input packet.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no beats of the current packet accumulated
// ACCUM | at least one non-last beat accumulated
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   s_axis_*        magnitude input stream (tdata 4*COORD_WIDTH bits)
//   m_axis_tdata    {count, max, sum}, count in the MSBs
//   m_axis_tuser    bit0 sum/count saturated, bit1 magnitude clamped
//   m_axis_tvalid   result valid; m_axis_tlast mirrors it
//   m_axis_tready   downstream accept
module vec_mag_path_acc
  import vec_mag_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF,
  parameter int MAG_WIDTH   = MAG_WIDTH_DEF,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [4*COORD_WIDTH-1:0]               s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [CNT_WIDTH+MAG_WIDTH+SUM_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                             m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready
);

  localparam int IN_WIDTH  = 4 * COORD_WIDTH;
  localparam int OUT_WIDTH = CNT_WIDTH + MAG_WIDTH + SUM_WIDTH;

  vec_mag_state_e         state_q, state_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [MAG_WIDTH-1:0]   max_q, max_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   clamp_q, clamp_d;
  logic                   m_valid_q, m_valid_d;
  logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
  logic [1:0]             m_user_q, m_user_d;

  logic                   accept;
  logic                   clamp_hit;
  logic [MAG_WIDTH-1:0]   mag;
  logic [SUM_WIDTH-1:0]   mag_sum_op;
  logic                   mag_too_wide;
  logic [SUM_WIDTH-1:0]   sum_add;
  logic                   sum_add_ovf;
  logic                   sum_sat;
  logic [SUM_WIDTH-1:0]   sum_next;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   cnt_ovf;
  logic [MAG_WIDTH-1:0]   max_next;
  logic                   sat_next;
  logic                   clamp_next;

  // Any set bit above the magnitude field means the upstream value does
  // not fit; it is clamped to full scale and flagged.
  if (MAG_WIDTH < IN_WIDTH) begin : g_clamp
    assign clamp_hit = |s_axis_tdata[IN_WIDTH-1:MAG_WIDTH];
  end else begin : g_no_clamp
    assign clamp_hit = 1'b0;
  end

  assign mag = clamp_hit ? '1 : s_axis_tdata[MAG_WIDTH-1:0];

  // A sum narrower than a magnitude saturates as soon as the magnitude
  // alone exceeds the sum range.
  if (MAG_WIDTH > SUM_WIDTH) begin : g_sum_narrow
    assign mag_sum_op   = mag[SUM_WIDTH-1:0];
    assign mag_too_wide = |mag[MAG_WIDTH-1:SUM_WIDTH];
  end else begin : g_sum_wide
    assign mag_sum_op   = SUM_WIDTH'(mag);
    assign mag_too_wide = 1'b0;
  end

  vec_mag_sat_add #(.WIDTH(SUM_WIDTH)) u_sum_add (
    .a        (sum_q),
    .b        (mag_sum_op),
    .result   (sum_add),
    .overflow (sum_add_ovf)
  );

  vec_mag_sat_add #(.WIDTH(CNT_WIDTH)) u_cnt_add (
    .a        (cnt_q),
    .b        (CNT_WIDTH'(1)),
    .result   (cnt_next),
    .overflow (cnt_ovf)
  );

  assign sum_sat    = sum_add_ovf | mag_too_wide;
  assign sum_next   = sum_sat ? '1 : sum_add;
  assign max_next   = (mag > max_q) ? mag : max_q;
  assign sat_next   = sat_q | sum_sat | cnt_ovf;
  assign clamp_next = clamp_q | clamp_hit;

  // A pending result that drains this cycle frees the output register,
  // so a new tlast beat can be taken in the same edge.
  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    clamp_d   = clamp_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (accept && !s_axis_tlast) state_d = ACCUM;
      ACCUM:   if (accept && s_axis_tlast)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (s_axis_tlast) begin
        m_valid_d             = 1'b1;
        m_data_d              = {cnt_next, max_next, sum_next};
        m_user_d[TUSER_SAT]   = sat_next;
        m_user_d[TUSER_CLAMP] = clamp_next;
        sum_d                 = '0;
        max_d                 = '0;
        cnt_d                 = '0;
        sat_d                 = 1'b0;
        clamp_d               = 1'b0;
      end else begin
        sum_d   = sum_next;
        max_d   = max_next;
        cnt_d   = cnt_next;
        sat_d   = sat_next;
        clamp_d = clamp_next;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      clamp_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      clamp_q   <= clamp_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_vec_mag_path_acc.sv
module tb_vec_mag_path_acc;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // DUT A: default widths
  logic [31:0] s_tdata_a;
  logic        s_tvalid_a, s_tlast_a, s_tready_a;
  logic [63:0] m_tdata_a;
  logic [1:0]  m_tuser_a;
  logic        m_tvalid_a, m_tlast_a, m_tready_a;

  // DUT B: SUM_WIDTH = 10
  logic [31:0] s_tdata_b;
  logic        s_tvalid_b, s_tlast_b, s_tready_b;
  logic [41:0] m_tdata_b;
  logic [1:0]  m_tuser_b;
  logic        m_tvalid_b, m_tlast_b, m_tready_b;

  vec_mag_path_acc u_dut_a (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata_a),
    .s_axis_tvalid (s_tvalid_a),
    .s_axis_tlast  (s_tlast_a),
    .s_axis_tready (s_tready_a),
    .m_axis_tdata  (m_tdata_a),
    .m_axis_tuser  (m_tuser_a),
    .m_axis_tvalid (m_tvalid_a),
    .m_axis_tlast  (m_tlast_a),
    .m_axis_tready (m_tready_a)
  );

  vec_mag_path_acc #(.SUM_WIDTH(10)) u_dut_b (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata_b),
    .s_axis_tvalid (s_tvalid_b),
    .s_axis_tlast  (s_tlast_b),
    .s_axis_tready (s_tready_b),
    .m_axis_tdata  (m_tdata_b),
    .m_axis_tuser  (m_tuser_b),
    .m_axis_tvalid (m_tvalid_b),
    .m_axis_tlast  (m_tlast_b),
    .m_axis_tready (m_tready_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rnd_done;

  logic [65:0] got_a[$];
  logic [65:0] got_b[$];
  int          cyc_a[$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so a handshake seen here happens at the next edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_tvalid_a && m_tready_a) begin
        got_a.push_back(66'({m_tuser_a, m_tdata_a}));
        cyc_a.push_back(cyc);
      end
      if (m_tvalid_b && m_tready_b) got_b.push_back(66'({m_tuser_b, m_tdata_b}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Packet result from the plain arithmetic rules: {tuser, count, max, sum},
  // with the sum field sw bits wide.
  function automatic logic [65:0] model(input logic [31:0] beats[$], input int sw);
    longint total = 0;
    longint lim;
    longint s;
    int     mx = 0;
    int     n;
    int     m;
    logic [1:0] u = 2'b00;
    lim = (longint'(1) << sw) - 1;
    foreach (beats[i]) begin
      if (beats[i] > 32'd65535) begin
        m = 65535;
        u[1] = 1'b1;
      end else begin
        m = int'(beats[i]);
      end
      total += m;
      if (m > mx) mx = m;
    end
    n = beats.size();
    if (total > lim) begin
      s = lim;
      u[0] = 1'b1;
    end else begin
      s = total;
    end
    if (n > 65535) begin
      n = 65535;
      u[0] = 1'b1;
    end
    return 66'(s) | (66'(mx) << sw) | (66'(n) << (sw + 16)) | (66'(u) << (sw + 32));
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input bit sel, input logic [31:0] d, input bit last);
    int  t = 0;
    bit  done = 0;
    if (sel) begin
      s_tdata_b = d; s_tlast_b = last; s_tvalid_b = 1'b1;
    end else begin
      s_tdata_a = d; s_tlast_a = last; s_tvalid_a = 1'b1;
    end
    while (!done) begin
      @(negedge aclk);
      if (sel ? s_tready_b : s_tready_a) begin
        done = 1;
      end else begin
        t++;
        if (t > 200) begin
          n_cmp++; n_bad++;
          $display("FAIL send_timeout: tready stayed low for %0d cycles, expected accept", t);
          done = 1;
        end
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic send_pkt(input bit sel, input logic [31:0] beats[$], input bit bubbles);
    for (int i = 0; i < beats.size(); i++) begin
      if (bubbles && ($urandom % 3 == 0)) begin
        if (sel) s_tvalid_b = 1'b0; else s_tvalid_a = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge aclk); #1;
        end
      end
      send_beat(sel, beats[i], i == beats.size() - 1);
    end
    if (sel) s_tvalid_b = 1'b0; else s_tvalid_a = 1'b0;
  endtask

  task automatic wait_results(input bit sel, input int n);
    int t = 0;
    while (((sel ? got_b.size() : got_a.size()) < n) && t < 300) begin
      @(negedge aclk);
      t++;
    end
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_tvalid_a = 0; s_tlast_a = 0; s_tdata_a = 0; m_tready_a = 1;
    s_tvalid_b = 0; s_tlast_b = 0; s_tdata_b = 0; m_tready_b = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_cmp++; if (m_tvalid_a !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid_a); end
    n_cmp++; if (m_tlast_a !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %0b expected 0", m_tlast_a); end
    n_cmp++; if (m_tdata_a !== 64'd0) begin n_bad++; $display("FAIL reset_tdata: got %0h expected 0", m_tdata_a); end
    n_cmp++; if (m_tuser_a !== 2'd0) begin n_bad++; $display("FAIL reset_tuser: got %0h expected 0", m_tuser_a); end
    n_cmp++; if (s_tready_a !== 1'b1) begin n_bad++; $display("FAIL reset_s_tready: got %0b expected 1", s_tready_a); end
    n_cmp++; if (m_tvalid_b !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid_b: got %0b expected 0", m_tvalid_b); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] q[$];
    logic [65:0] exp;
    q.push_back(3); q.push_back(4); q.push_back(5);
    exp = model(q, 32);
    send_pkt(0, q, 0);
    @(negedge aclk);
    n_cmp++; if (m_tvalid_a !== 1'b1) begin n_bad++; $display("FAIL basic_latency: tvalid %0b one cycle after tlast, expected 1", m_tvalid_a); end
    n_cmp++; if (m_tlast_a !== 1'b1) begin n_bad++; $display("FAIL basic_tlast: got %0b expected 1", m_tlast_a); end
    @(posedge aclk); #1;
    wait_results(0, 1);
    n_cmp++; if (got_a.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d results expected 1", got_a.size()); end
    if (got_a.size() >= 1) begin
      n_cmp++; if (got_a[0] !== exp) begin n_bad++; $display("FAIL basic_result: got %0h expected %0h", got_a[0], exp); end
    end
    got_a.delete(); cyc_a.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [65:0] exps[$];
    q.push_back(361);
    exps.push_back(model(q, 32));
    send_pkt(0, q, 0);
    for (int i = 0; i < 10; i++) begin
      q.delete();
      q.push_back($urandom_range(0, 361));
      exps.push_back(model(q, 32));
      send_pkt(0, q, 0);
    end
    wait_results(0, 11);
    n_cmp++; if (got_a.size() != 11) begin n_bad++; $display("FAIL b2b_count: got %0d results expected 11", got_a.size()); end
    for (int i = 0; i < 11 && i < got_a.size(); i++) begin
      n_cmp++; if (got_a[i] !== exps[i]) begin n_bad++; $display("FAIL b2b_result[%0d]: got %0h expected %0h", i, got_a[i], exps[i]); end
    end
    for (int i = 2; i < 11 && i < cyc_a.size(); i++) begin
      n_cmp++; if (cyc_a[i] != cyc_a[i-1] + 1) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 1", i, cyc_a[i] - cyc_a[i-1]); end
    end
    got_a.delete(); cyc_a.delete();
  endtask

  task automatic test_stall();
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [65:0] e1, e2;
    q1.push_back(10); q1.push_back(20);
    q2.push_back(1); q2.push_back(2); q2.push_back(3);
    e1 = model(q1, 32);
    e2 = model(q2, 32);
    m_tready_a = 1'b1;
    send_pkt(0, q1, 0);
    m_tready_a = 1'b0;
    fork
      send_pkt(0, q2, 0);
      begin
        repeat (5) begin
          @(negedge aclk);
          n_cmp++; if (m_tvalid_a !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %0b expected 1", m_tvalid_a); end
          n_cmp++; if ({m_tuser_a, m_tdata_a} !== e1) begin n_bad++; $display("FAIL stall_hold: got %0h expected %0h", {m_tuser_a, m_tdata_a}, e1); end
          n_cmp++; if (s_tready_a !== 1'b0) begin n_bad++; $display("FAIL stall_s_tready: got %0b expected 0", s_tready_a); end
        end
        @(posedge aclk); #1;
        m_tready_a = 1'b1;
      end
    join
    wait_results(0, 2);
    n_cmp++; if (got_a.size() != 2) begin n_bad++; $display("FAIL stall_count: got %0d results expected 2", got_a.size()); end
    if (got_a.size() >= 2) begin
      n_cmp++; if (got_a[0] !== e1) begin n_bad++; $display("FAIL stall_first: got %0h expected %0h", got_a[0], e1); end
      n_cmp++; if (got_a[1] !== e2) begin n_bad++; $display("FAIL stall_second: got %0h expected %0h", got_a[1], e2); end
    end
    got_a.delete(); cyc_a.delete();
  endtask

  task automatic test_sum_sat();
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [65:0] e1, e2;
    q1.push_back(600); q1.push_back(600);
    q2.push_back(1);
    e1 = model(q1, 10);
    e2 = model(q2, 10);
    send_pkt(1, q1, 0);
    send_pkt(1, q2, 0);
    wait_results(1, 2);
    n_cmp++; if (got_b.size() != 2) begin n_bad++; $display("FAIL sat_count: got %0d results expected 2", got_b.size()); end
    if (got_b.size() >= 2) begin
      n_cmp++; if (got_b[0] !== e1) begin n_bad++; $display("FAIL sat_result: got %0h expected %0h", got_b[0], e1); end
      n_cmp++; if (got_b[1] !== e2) begin n_bad++; $display("FAIL sat_next_clean: got %0h expected %0h", got_b[1], e2); end
    end
    got_b.delete();
  endtask

  task automatic test_clamp();
    logic [31:0] q[$];
    logic [65:0] exp;
    q.push_back(32'h0001_0000);
    exp = model(q, 32);
    send_pkt(0, q, 0);
    wait_results(0, 1);
    n_cmp++; if (got_a.size() != 1) begin n_bad++; $display("FAIL clamp_count: got %0d results expected 1", got_a.size()); end
    if (got_a.size() >= 1) begin
      n_cmp++; if (got_a[0] !== exp) begin n_bad++; $display("FAIL clamp_result: got %0h expected %0h", got_a[0], exp); end
    end
    got_a.delete(); cyc_a.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    logic [65:0] exp;
    q.push_back(7);
    exp = model(q, 32);
    send_beat(0, 50, 0);
    send_beat(0, 60, 0);
    s_tvalid_a = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    n_cmp++; if (m_tvalid_a !== 1'b0) begin n_bad++; $display("FAIL midreset_tvalid: got %0b expected 0", m_tvalid_a); end
    @(posedge aclk); #1;
    n_cmp++; if (m_tvalid_a !== 1'b0) begin n_bad++; $display("FAIL midreset_tvalid_after: got %0b expected 0", m_tvalid_a); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send_pkt(0, q, 0);
    wait_results(0, 1);
    n_cmp++; if (got_a.size() != 1) begin n_bad++; $display("FAIL midreset_count: got %0d results expected 1", got_a.size()); end
    if (got_a.size() >= 1) begin
      n_cmp++; if (got_a[0] !== exp) begin n_bad++; $display("FAIL midreset_result: got %0h expected %0h", got_a[0], exp); end
    end
    got_a.delete(); cyc_a.delete();
  endtask

  task automatic test_random(input bit sel);
    logic [31:0] q[$];
    logic [65:0] exps[$];
    int          w;
    int          n;
    w = sel ? 10 : 32;
    rnd_done = 0;
    fork
      begin
        for (int p = 0; p < 8; p++) begin
          q.delete();
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) begin
            if ($urandom % 4 == 0) q.push_back($urandom);
            else q.push_back($urandom_range(0, 1000));
          end
          exps.push_back(model(q, w));
          send_pkt(sel, q, 1);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge aclk); #1;
          if (sel) m_tready_b = 1'($urandom % 2); else m_tready_a = 1'($urandom % 2);
        end
        if (sel) m_tready_b = 1'b1; else m_tready_a = 1'b1;
      end
    join
    wait_results(sel, 8);
    if (sel) begin
      n_cmp++; if (got_b.size() != 8) begin n_bad++; $display("FAIL rand_b_count: got %0d results expected 8", got_b.size()); end
      for (int i = 0; i < 8 && i < got_b.size(); i++) begin
        n_cmp++; if (got_b[i] !== exps[i]) begin n_bad++; $display("FAIL rand_b_result[%0d]: got %0h expected %0h", i, got_b[i], exps[i]); end
      end
      got_b.delete();
    end else begin
      n_cmp++; if (got_a.size() != 8) begin n_bad++; $display("FAIL rand_a_count: got %0d results expected 8", got_a.size()); end
      for (int i = 0; i < 8 && i < got_a.size(); i++) begin
        n_cmp++; if (got_a[i] !== exps[i]) begin n_bad++; $display("FAIL rand_a_result[%0d]: got %0h expected %0h", i, got_a[i], exps[i]); end
      end
      got_a.delete(); cyc_a.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_sum_sat();
    test_clamp();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
